// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Purpose  : Walks every N-bit input vector, drives it to two combinational
//            DUTs, waits DWELL settle cycles, then compares their outputs.
//            Counts mismatches, captures the first failing vector and reports
//            pass/fail through a start/busy/done handshake.
// Options  : SWEEP_GRAY_EN - when defined, vectors are issued in Gray order
//            (one input bit toggles per step) instead of binary order.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
   parameter int N     = 5,   // vector width, 1..16
   parameter int DWELL = 10   // settle cycles per vector, 1..65535
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic         abort_i,
   input  logic         f_in_i,
   input  logic         g_in_i,
   output logic [N-1:0] vec_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [N:0]   err_cnt_o,
   output logic [N-1:0] first_err_vec_o,
   output logic         first_err_valid_o,
   output logic         pass_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Terminal values for the dwell counter and the vector index.
   localparam logic [15:0]  C_DWELL_LAST = 16'(DWELL - 1);
   localparam logic [N-1:0] C_IDX_LAST   = {N{1'b1}};

   state_t         state_q, state_d;
   logic [N-1:0]   idx_q, idx_d;
   logic [15:0]    dwell_q, dwell_d;
   logic [N:0]     err_q, err_d;
   logic [N-1:0]   fvec_q, fvec_d;
   logic           fvalid_q, fvalid_d;
   logic           pass_q, pass_d;

   logic [N-1:0]   w_vec;
   logic           w_mismatch;

   // Vector ordering: the index always counts in binary; only the mapping
   // from index to driven vector changes between builds, so sweep length
   // and timing are identical in both.
`ifdef SWEEP_GRAY_EN
   assign w_vec = idx_q ^ (idx_q >> 1);
`else
   assign w_vec = idx_q;
`endif

   assign w_mismatch = f_in_i ^ g_in_i;

   // State and result registers; reset has priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         dwell_q  <= '0;
         err_q    <= '0;
         fvec_q   <= '0;
         fvalid_q <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         dwell_q  <= dwell_d;
         err_q    <= err_d;
         fvec_q   <= fvec_d;
         fvalid_q <= fvalid_d;
         pass_q   <= pass_d;
      end
   end

   // Next-state, result update and handshake decode.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      dwell_d  = dwell_q;
      err_d    = err_q;
      fvec_d   = fvec_q;
      fvalid_d = fvalid_q;
      pass_d   = pass_q;
      busy_o   = 1'b0;
      done_o   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // start beats abort here; abort only matters mid-sweep.
            if (start_i) begin
               state_d  = S_SETTLE;
               idx_d    = '0;
               dwell_d  = '0;
               err_d    = '0;
               fvec_d   = '0;
               fvalid_d = 1'b0;
               pass_d   = 1'b0;
            end
         end

         S_SETTLE: begin
            busy_o = 1'b1;
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (dwell_q == C_DWELL_LAST) begin
               dwell_d = '0;
               state_d = S_CHECK;
            end else begin
               dwell_d = dwell_q + 16'd1;
            end
         end

         S_CHECK: begin
            busy_o = 1'b1;
            // An abort in this cycle discards the sample entirely.
            if (abort_i) begin
               state_d = S_IDLE;
            end else begin
               if (w_mismatch) begin
                  err_d = err_q + {{N{1'b0}}, 1'b1};
                  if (!fvalid_q) begin
                     fvec_d   = w_vec;
                     fvalid_d = 1'b1;
                  end
               end
               if (idx_q == C_IDX_LAST) begin
                  // pass must already be valid in the done cycle.
                  pass_d  = (err_q == '0) && !w_mismatch;
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + {{(N-1){1'b0}}, 1'b1};
                  state_d = S_SETTLE;
               end
            end
         end

         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign vec_o             = w_vec;
   assign err_cnt_o         = err_q;
   assign first_err_vec_o   = fvec_q;
   assign first_err_valid_o = fvalid_q;
   assign pass_o            = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweeper
// Purpose  : Directed self-checking bench for truth_table_sweeper (N=5,
//            DWELL=3, so one sweep is 32*4 = 128 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

   localparam int N     = 5;
   localparam int DWELL = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         f_in;
   logic         g_in;
   logic [N-1:0] vec;
   logic         busy;
   logic         done;
   logic [N:0]   err_cnt;
   logic [N-1:0] first_err_vec;
   logic         first_err_valid;
   logic         pass;

   int n_cmp  = 0;
   int n_fail = 0;
   int mode   = 0;

   truth_table_sweeper #(.N(N), .DWELL(DWELL)) dut (
      .clk               (clk),
      .rst               (rst),
      .start_i           (start),
      .abort_i           (abort),
      .f_in_i            (f_in),
      .g_in_i            (g_in),
      .vec_o             (vec),
      .busy_o            (busy),
      .done_o            (done),
      .err_cnt_o         (err_cnt),
      .first_err_vec_o   (first_err_vec),
      .first_err_valid_o (first_err_valid),
      .pass_o            (pass)
   );

   always #5 clk = ~clk;

   // Two "DUTs": identical except for the fault pattern selected by mode.
   always_comb begin
      f_in = vec[0];
      g_in = vec[0];
      case (mode)
         1: g_in = vec[0] ^ (vec == 5'd22);
         2: begin f_in = 1'b1; g_in = 1'b0; end
         3: g_in = vec[0] ^ ((vec == 5'd1) || (vec == 5'd3));
         4: g_in = vec[0] ^ (vec == 5'd6);
         default: ;
      endcase
   end

   function automatic logic [N-1:0] exp_vec(input int k);
      logic [N-1:0] b;
      b = k[N-1:0];
`ifdef SWEEP_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   // Starts a sweep and returns the number of cycles from the accepting edge
   // to the first cycle with done high (-1 on timeout). Optionally pulses
   // start again at cycle pulse_at to show it is ignored.
   task automatic run_sweep(input int pulse_at, output int cyc);
      bit seen;
      seen = 0;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      cyc = 0;
      for (int k = 0; k < 2000 && !seen; k++) begin
         @(negedge clk);
         start = (cyc == pulse_at);
         if (cyc == 0) begin
            n_cmp++;
            if (busy !== 1'b1 || vec !== 5'd0) begin
               n_fail++;
               $display("FAIL sweep_first_cycle busy=%b vec=%0d required busy=1 vec=0", busy, vec);
            end
         end
         if (done === 1'b1) seen = 1;
         else begin
            @(posedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      if (!seen) cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({vec, busy, done, err_cnt, first_err_vec, first_err_valid, pass} !== '0) begin
         n_fail++;
         $display("FAIL reset_values vec=%0d busy=%b done=%b err=%0d fev=%0d fv=%b pass=%b required all 0",
                  vec, busy, done, err_cnt, first_err_vec, first_err_valid, pass);
      end
   endtask

   task automatic test_clean();
      int cyc;
      mode = 0;
      run_sweep(-1, cyc);
      n_cmp++;
      if (cyc !== 128) begin n_fail++; $display("FAIL clean_latency got %0d required 128", cyc); end
      n_cmp++;
      if (err_cnt !== 6'd0 || pass !== 1'b1 || first_err_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clean_result err=%0d pass=%b fv=%b required 0 1 0", err_cnt, pass, first_err_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL clean_after_done done=%b busy=%b pass=%b required 0 0 1", done, busy, pass);
      end
   endtask

   task automatic test_single_err();
      int cyc;
      mode = 1;
      run_sweep(-1, cyc);
      n_cmp++;
      if (cyc !== 128) begin n_fail++; $display("FAIL single_latency got %0d required 128", cyc); end
      n_cmp++;
      if (err_cnt !== 6'd1 || first_err_vec !== 5'd22 || first_err_valid !== 1'b1 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL single_result err=%0d fev=%0d fv=%b pass=%b required 1 22 1 0",
                  err_cnt, first_err_vec, first_err_valid, pass);
      end
   endtask

   task automatic test_all_err();
      int cyc;
      mode = 2;
      run_sweep(50, cyc);
      n_cmp++;
      if (cyc !== 128) begin n_fail++; $display("FAIL allerr_latency got %0d required 128", cyc); end
      n_cmp++;
      if (err_cnt !== 6'b100000 || first_err_vec !== 5'd0 || first_err_valid !== 1'b1 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL allerr_result err=%0d fev=%0d fv=%b pass=%b required 32 0 1 0",
                  err_cnt, first_err_vec, first_err_valid, pass);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      mode = 0;
      run_sweep(-1, cyc);
      // start during the done cycle must be ignored
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_start_in_done busy=%b pass=%b required 0 1", busy, pass);
      end
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || pass !== 1'b0 || err_cnt !== 6'd0) begin
         n_fail++;
         $display("FAIL b2b_restart busy=%b pass=%b err=%0d required 1 0 0", busy, pass, err_cnt);
      end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_abort busy=%b required 0", busy); end
   endtask

   task automatic test_rst_mid();
      int cyc;
      bit hit;
      hit = 0;
      mode = 2;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 1000 && !hit; k++) begin
         if (vec === 5'd9) hit = 1;
         else @(negedge clk);
      end
      n_cmp++;
      if (!hit) begin n_fail++; $display("FAIL rstmid_reach_vec9 got timeout required vec=9"); end
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      n_cmp++;
      if ({vec, busy, done, err_cnt, first_err_vec, first_err_valid, pass} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_values vec=%0d busy=%b done=%b err=%0d fev=%0d fv=%b pass=%b required all 0",
                  vec, busy, done, err_cnt, first_err_vec, first_err_valid, pass);
      end
      mode = 0;
      run_sweep(-1, cyc);
      n_cmp++;
      if (cyc !== 128 || err_cnt !== 6'd0 || pass !== 1'b1 || first_err_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_resweep cyc=%0d err=%0d pass=%b fv=%b required 128 0 1 0",
                  cyc, err_cnt, pass, first_err_valid);
      end
   endtask

   task automatic test_abort();
      bit hit;
      bit bad;
      hit = 0;
      bad = 0;
      mode = 3;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 1000 && !hit; k++) begin
         if (vec === 5'd4) hit = 1;
         else @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      n_cmp++;
      if (!hit || busy !== 1'b0 || err_cnt !== 6'd2 || first_err_vec !== 5'd1 ||
          first_err_valid !== 1'b1 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state hit=%b busy=%b err=%0d fev=%0d fv=%b pass=%b required 1 0 2 1 1 0",
                  hit, busy, err_cnt, first_err_vec, first_err_valid, pass);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      n_cmp++;
      if (bad) begin n_fail++; $display("FAIL abort_no_done got done/busy activity required none"); end

      // Abort in the CHECK cycle of the second vector: its mismatch is dropped.
      mode = 2;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      for (int c = 0; c <= 7; c++) begin
         @(negedge clk);
         start = 1'b0;
         abort = (c == 7);
         if (c < 7) @(posedge clk);
      end
      @(negedge clk); abort = 1'b0;
      n_cmp++;
      if (err_cnt !== 6'd1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_in_check err=%0d busy=%b required 1 0", err_cnt, busy);
      end
   endtask

   task automatic test_order();
      mode = 4;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 128; c++) begin
         @(negedge clk);
         start = 1'b0;
         n_cmp++;
         if (vec !== exp_vec(c / 4)) begin
            n_fail++;
            $display("FAIL order_vec cycle=%0d got %0d required %0d", c, vec, exp_vec(c / 4));
         end
         if (c < 127) @(posedge clk);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b1 || err_cnt !== 6'd1 || first_err_vec !== 5'd6 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL order_result done=%b err=%0d fev=%0d pass=%b required 1 1 6 0",
                  done, err_cnt, first_err_vec, pass);
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_single_err();
      test_all_err();
      test_back_to_back();
      test_rst_mid();
      test_abort();
      test_order();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
